regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised register file for the pipelined core: 2 async read ports, 2 sync write ports (E, M).
//  Includes a per-register scoreboard that tracks in-flight destinations and flags RAW hazards to the stall logic.
//  Sits in decode, between the fetch/decode control and the writeback bus.
// PARAMETERS
//  DATA_W   64   register width in bits
//  ADDR_W   4    register index width
//  NREGS    15   number of physical registers; index (2**ADDR_W)-1 = NONE (no register)
// PORTS
//  clk_i         in   1        clock, rising edge
//  rst_n_i       in   1        reset, asynchronous, active-low
//  srcA_i        in   ADDR_W   read index A (NONE -> reads 0)
//  srcB_i        in   ADDR_W   read index B (NONE -> reads 0)
//  valA_o        out  DATA_W   read data A
//  valB_o        out  DATA_W   read data B
//  dstE_i        in   ADDR_W   writeback index E (NONE = no write)
//  valE_i        in   DATA_W   writeback data E
//  dstM_i        in   ADDR_W   writeback index M (NONE = no write)
//  valM_i        in   DATA_W   writeback data M
//  issue_v_i     in   1        instruction leaves decode this cycle; reserve its destinations
//  issue_dstE_i  in   ADDR_W   dstE of issuing instruction (NONE = none)
//  issue_dstM_i  in   ADDR_W   dstM of issuing instruction (NONE = none)
//  hazard_o      out  1        srcA_i or srcB_i has a pending, unresolved write
//  busy_o        out  NREGS    scoreboard vector, bit i = reg i pending
// BEHAVIOUR
//  - Reset (async, rst_n_i=0): all NREGS registers = 0, busy_o = 0, no writes occur while in reset.
//  - Reads combinational, zero latency; index NONE or >= NREGS returns 0.
//  - Writes at posedge clk_i; index NONE or >= NREGS is ignored.
//  - dstE_i == dstM_i (valid): valM_i wins (popq %rsp semantics).
//  - Scoreboard: per reg, 2-bit pending counter cnt[i], sat at 3; busy_o[i] = (cnt[i] != 0).
//  - Each posedge: cnt[i] += (issue_v_i && (issue_dstE_i==i)) + (issue_v_i && (issue_dstM_i==i) && issue_dstM_i!=issue_dstE_i),
//    cnt[i] -= 1 if (dstE_i==i || dstM_i==i) [same-cycle E and M to same reg releases 1]; increment and release same cycle -> net.
//  - Release of a reg with cnt=0: no change (no underflow); saturated cnt=3 stays 3 on further issue (counter never wraps).
//  - hazard_o combinational: (srcA_i valid && busy_o[srcA_i]) || (srcB_i valid && busy_o[srcB_i]); NONE never hazards.
//  - issue_v_i=0: issue_dst* ignored. Reset mid-operation clears all pending counts immediately.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - valA_o/valB_o forward same-cycle writeback data: srcX==dstM_i -> valM_i, else srcX==dstE_i -> valE_i, else array.
//    - hazard_o suppressed for a source whose cnt==1 and which is being written back this cycle.
//  Not defined: reads return array contents only (written value visible the cycle after the write edge);
//    hazard_o purely from busy_o.
// TESTING
//  1. Reset: assert rst_n_i=0 mid-run -> all valA_o/valB_o=0 for every index, busy_o=0, hazard_o=0.
//  2. Write E: dstE_i=3, valE_i=64'hDEAD_BEEF, edge; srcA_i=3 -> valA_o=64'hDEAD_BEEF; srcB_i=NONE -> 0.
//  3. Conflict: dstE_i=dstM_i=4, valE_i=1, valM_i=2, edge -> reg4=2; busy unchanged if cnt[4]=0.
//  4. Scoreboard: issue dstE=5, edge -> busy_o[5]=1, srcA_i=5 -> hazard_o=1; dstE_i=5 writeback, edge -> busy_o[5]=0, hazard_o=0.
//  5. Double pending: issue dstE=2 twice, one writeback -> busy_o[2]=1; second writeback -> 0; extra writeback -> stays 0.
//  6. Bypass (REGFILE_BYPASS_EN): cnt[6]=1, dstM_i=6, valM_i=64'h55, srcA_i=6 same cycle -> valA_o=64'h55, hazard_o=0;
//     without macro -> valA_o=old value, hazard_o=1.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Decode-stage register file with two combinational read ports,
//            two synchronous writeback ports (E, M) and a per-register
//            scoreboard. The scoreboard counts in-flight destinations and
//            raises a RAW hazard to the stall logic.
// Optional : REGFILE_BYPASS_EN - forward same-cycle writeback data to the
//            read ports, and drop the hazard for a source whose last pending
//            write is landing this cycle.
// Ports    : clk_i, rst_n_i (async, active-low)
//            srcA_i/srcB_i  -> valA_o/valB_o   read ports (NONE reads 0)
//            dstE_i/valE_i, dstM_i/valM_i      writeback ports (M wins ties)
//            issue_v_i, issue_dstE_i/M_i       destination reservation
//            hazard_o, busy_o                  scoreboard outputs
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] srcA_i,
    input  logic [ADDR_W-1:0] srcB_i,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o,
    input  logic [ADDR_W-1:0] dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [ADDR_W-1:0] dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    input  logic              issue_v_i,
    input  logic [ADDR_W-1:0] issue_dstE_i,
    input  logic [ADDR_W-1:0] issue_dstM_i,
    output logic              hazard_o,
    output logic [NREGS-1:0]  busy_o
);

    // Index (2**ADDR_W)-1 is NONE. Every physical index is below NREGS,
    // which never exceeds NONE, so a plain equality match against a
    // physical index already rejects NONE and out-of-range indices.
    localparam logic [ADDR_W-1:0] c_none = '1;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [1:0]        r_cnt  [NREGS];
    logic [1:0]        w_cnt_nxt [NREGS];
    logic [NREGS-1:0]  w_written;
    logic [DATA_W-1:0] w_arr_a;
    logic [DATA_W-1:0] w_arr_b;
    logic              w_haz_a;
    logic              w_haz_b;

    // Saturating pending-count update: add reservations first, then take
    // one release, so increment and release in the same cycle cancel.
    function automatic logic [1:0] f_next_cnt(input logic [1:0] cnt,
                                              input logic       inc_e,
                                              input logic       inc_m,
                                              input logic       rel);
        logic [2:0] s;
        s = {1'b0, cnt} + {2'b00, inc_e} + {2'b00, inc_m};
        if (rel && (s != 3'd0))
            s = s - 3'd1;
        return (s > 3'd3) ? 2'd3 : s[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Register array. M is evaluated first so it wins a same-index tie.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (dstM_i == ADDR_W'(i))
                    r_regs[i] <= valM_i;
                else if (dstE_i == ADDR_W'(i))
                    r_regs[i] <= valE_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        w_written = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_written[i] = (dstE_i == ADDR_W'(i)) || (dstM_i == ADDR_W'(i));
            w_cnt_nxt[i] = f_next_cnt(
                r_cnt[i],
                issue_v_i && (issue_dstE_i == ADDR_W'(i)),
                issue_v_i && (issue_dstM_i == ADDR_W'(i)) &&
                    (issue_dstM_i != issue_dstE_i),
                w_written[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= 2'd0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= w_cnt_nxt[i];
        end
    end

    always_comb begin
        busy_o = '0;
        for (int i = 0; i < NREGS; i++)
            busy_o[i] = (r_cnt[i] != 2'd0);
    end

    // ------------------------------------------------------------------
    // Read ports and hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        w_arr_a = '0;
        w_arr_b = '0;
        w_haz_a = 1'b0;
        w_haz_b = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA_i == ADDR_W'(i)) begin
                w_arr_a = r_regs[i];
`ifdef REGFILE_BYPASS_EN
                w_haz_a = busy_o[i] && !((r_cnt[i] == 2'd1) && w_written[i]);
`else
                w_haz_a = busy_o[i];
`endif
            end
            if (srcB_i == ADDR_W'(i)) begin
                w_arr_b = r_regs[i];
`ifdef REGFILE_BYPASS_EN
                w_haz_b = busy_o[i] && !((r_cnt[i] == 2'd1) && w_written[i]);
`else
                w_haz_b = busy_o[i];
`endif
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is blocked in reset so that reset reads stay at zero.
    always_comb begin
        valA_o = w_arr_a;
        valB_o = w_arr_b;
        if (rst_n_i && (srcA_i != c_none)) begin
            if (srcA_i == dstM_i)      valA_o = valM_i;
            else if (srcA_i == dstE_i) valA_o = valE_i;
        end
        if (rst_n_i && (srcB_i != c_none)) begin
            if (srcB_i == dstM_i)      valB_o = valM_i;
            else if (srcB_i == dstE_i) valB_o = valE_i;
        end
    end
`else
    assign valA_o = w_arr_a;
    assign valB_o = w_arr_b;
`endif

    assign hazard_o = w_haz_a || w_haz_b;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb: directed vector table,
//            hand sequences for saturation / bypass / mid-run reset, and a
//            randomized phase against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int         DW = 64;
    localparam int         AW = 4;
    localparam int         NR = 15;
    localparam logic [3:0] N  = 4'hF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] srcA, srcB, dstE, dstM, iE, iM;
    logic [DW-1:0] valE, valM;
    logic          iv;
    logic [DW-1:0] valA, valB;
    logic          hazard;
    logic [NR-1:0] busy;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [DW-1:0] m_regs [NR];
    int            m_cnt  [NR];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .srcA_i(srcA), .srcB_i(srcB), .valA_o(valA), .valB_o(valB),
        .dstE_i(dstE), .valE_i(valE), .dstM_i(dstM), .valM_i(valM),
        .issue_v_i(iv), .issue_dstE_i(iE), .issue_dstM_i(iM),
        .hazard_o(hazard), .busy_o(busy)
    );

    typedef struct {
        logic [3:0]  sa, sb, de;
        logic [63:0] ve;
        logic [3:0]  dm;
        logic [63:0] vm;
        logic        iv;
        logic [3:0]  ie, im;
        logic [63:0] ea, eb;
        logic        eh;
        logic [14:0] ebusy;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic [3:0] sa, logic [3:0] sb,
                                logic [3:0] de, logic [63:0] ve,
                                logic [3:0] dm, logic [63:0] vm,
                                logic v, logic [3:0] ie, logic [3:0] im,
                                logic [63:0] ea, logic [63:0] eb,
                                logic eh, logic [14:0] ebusy);
        vec_t t;
        t.sa = sa; t.sb = sb; t.de = de; t.ve = ve; t.dm = dm; t.vm = vm;
        t.iv = v; t.ie = ie; t.im = im; t.ea = ea; t.eb = eb; t.eh = eh;
        t.ebusy = ebusy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input logic v, input logic [3:0] ie,
                         input logic [3:0] im);
        srcA = sa; srcB = sb; dstE = de; valE = ve; dstM = dm; valM = vm;
        iv = v; iE = ie; iM = im;
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] sb);
        drive(sa, sb, N, 64'h0, N, 64'h0, 1'b0, N, N);
    endtask

    function automatic bit m_valid(logic [3:0] idx);
        return int'(idx) < NR;
    endfunction

    function automatic logic [DW-1:0] m_read(logic [3:0] src);
`ifdef REGFILE_BYPASS_EN
        if (rst_n && m_valid(src) && src == dstM) return valM;
        if (rst_n && m_valid(src) && src == dstE) return valE;
`endif
        return m_valid(src) ? m_regs[src] : '0;
    endfunction

    function automatic bit m_haz(logic [3:0] src);
        if (!m_valid(src) || m_cnt[src] == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (m_cnt[src] == 1 && (src == dstE || src == dstM)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [NR-1:0] m_busy();
        logic [NR-1:0] b;
        for (int i = 0; i < NR; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    // clock edge, then apply the architectural rules to the model
    task automatic tick();
        int n;
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                n = m_cnt[i];
                if (iv && int'(iE) == i) n++;
                if (iv && int'(iM) == i && iM != iE) n++;
                if (int'(dstE) == i || int'(dstM) == i) n--;
                m_cnt[i] = (n < 0) ? 0 : (n > 3) ? 3 : n;
            end
            if (m_valid(dstE)) m_regs[dstE] = valE;
            if (m_valid(dstM)) m_regs[dstM] = valM;
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " valA"}, valA, m_read(srcA));
        chk({tag, " valB"}, valB, m_read(srcB));
        chk({tag, " hazard"}, {63'b0, hazard}, {63'b0, m_haz(srcA) || m_haz(srcB)});
        chk({tag, " busy"}, {49'b0, busy}, {49'b0, m_busy()});
    endtask

    initial begin
        m_clear();
        rst_n = 1'b0;
        idle(N, N);
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // ---------------- directed vector table ----------------
        tbl[0]  = mk(4'd0, N, N, 0, N, 0, 0, N, N, 0, 0, 0, 15'h0);
        tbl[1]  = mk(4'd1, 4'd2, 4'd3, 64'hDEAD_BEEF, N, 0, 0, N, N, 0, 0, 0, 15'h0);
        tbl[2]  = mk(4'd3, N, 4'd4, 64'd1, 4'd4, 64'd2, 0, N, N, 64'hDEAD_BEEF, 0, 0, 15'h0);
        tbl[3]  = mk(4'd4, 4'd3, N, 0, N, 0, 1, 4'd5, N, 64'd2, 64'hDEAD_BEEF, 0, 15'h0);
        tbl[4]  = mk(4'd5, N, N, 0, N, 0, 0, N, N, 0, 0, 1, 15'h0020);
        tbl[5]  = mk(4'd0, N, 4'd5, 64'd77, N, 0, 0, N, N, 0, 0, 0, 15'h0020);
        tbl[6]  = mk(4'd5, N, N, 0, N, 0, 0, N, N, 64'd77, 0, 0, 15'h0);
        tbl[7]  = mk(N, N, N, 0, N, 0, 1, 4'd2, N, 0, 0, 0, 15'h0);
        tbl[8]  = mk(N, 4'd2, N, 0, N, 0, 1, 4'd2, N, 0, 0, 1, 15'h0004);
        tbl[9]  = mk(N, N, 4'd2, 64'h10, N, 0, 0, N, N, 0, 0, 0, 15'h0004);
        tbl[10] = mk(N, N, N, 0, 4'd2, 64'h20, 0, N, N, 0, 0, 0, 15'h0004);
        tbl[11] = mk(N, N, 4'd2, 64'h30, N, 0, 0, N, N, 0, 0, 0, 15'h0);
        tbl[12] = mk(4'd2, N, N, 0, N, 0, 0, N, N, 64'h30, 0, 0, 15'h0);
        tbl[13] = mk(N, N, N, 0, N, 0, 1, 4'd7, 4'd7, 0, 0, 0, 15'h0);
        tbl[14] = mk(4'd7, N, N, 0, N, 0, 0, N, N, 0, 0, 1, 15'h0080);
        tbl[15] = mk(N, N, 4'd7, 64'd9, N, 0, 0, N, N, 0, 0, 0, 15'h0080);
        tbl[16] = mk(4'd7, N, N, 0, N, 0, 0, N, N, 64'd9, 0, 0, 15'h0);

        for (int k = 0; k < 17; k++) begin
            drive(tbl[k].sa, tbl[k].sb, tbl[k].de, tbl[k].ve, tbl[k].dm,
                  tbl[k].vm, tbl[k].iv, tbl[k].ie, tbl[k].im);
            #2;
            chk($sformatf("vec%0d valA", k), valA, tbl[k].ea);
            chk($sformatf("vec%0d valB", k), valB, tbl[k].eb);
            chk($sformatf("vec%0d hazard", k), {63'b0, hazard}, {63'b0, tbl[k].eh});
            chk($sformatf("vec%0d busy", k), {49'b0, busy}, {49'b0, tbl[k].ebusy});
            tick();
        end

        // ---------------- saturation at 3 ----------------
        for (int k = 0; k < 4; k++) begin
            drive(N, N, N, 0, N, 0, 1'b1, 4'd8, N);
            tick();
        end
        idle(4'd8, N); #1;
        chk("sat after 4 issues busy8", {63'b0, busy[8]}, 64'd1);
        chk("sat after 4 issues hazard", {63'b0, hazard}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            drive(N, N, 4'd8, 64'h88, N, 0, 1'b0, N, N);
            tick();
            if (k == 1) chk("sat after 2 releases busy8", {63'b0, busy[8]}, 64'd1);
        end
        chk("sat after 3 releases busy8", {63'b0, busy[8]}, 64'd0);

        // ---------------- same-cycle writeback to a pending source ----------------
        drive(N, N, 4'd6, 64'h11, N, 0, 1'b0, N, N); tick();
        drive(N, N, N, 0, N, 0, 1'b1, 4'd6, N);       tick();
        drive(4'd6, N, N, 0, 4'd6, 64'h55, 1'b0, N, N); #2;
`ifdef REGFILE_BYPASS_EN
        chk("bypass valA", valA, 64'h55);
        chk("bypass hazard", {63'b0, hazard}, 64'd0);
`else
        chk("nobypass valA", valA, 64'h11);
        chk("nobypass hazard", {63'b0, hazard}, 64'd1);
`endif
        tick();
        idle(4'd6, N); #1;
        chk("post wb valA", valA, 64'h55);
        chk("post wb busy", {49'b0, busy}, 64'd0);

        // ---------------- reset mid-run ----------------
        drive(N, N, N, 0, N, 0, 1'b1, 4'd1, 4'd9); tick();
        idle(4'd1, 4'd9); #2;
        chk("pre-reset busy", {49'b0, busy}, 64'h0202);
        rst_n = 1'b0; #1;
        chk("reset busy", {49'b0, busy}, 64'd0);
        chk("reset hazard", {63'b0, hazard}, 64'd0);
        drive(N, N, 4'd3, {64{1'b1}}, N, 0, 1'b1, 4'd3, N);
        tick();
        idle(N, N);
        for (int k = 0; k < 16; k++) begin
            srcA = 4'(k); srcB = 4'(15 - k); #1;
            chk($sformatf("reset valA[%0d]", k), valA, 64'd0);
            chk($sformatf("reset valB[%0d]", 15 - k), valB, 64'd0);
        end
        chk("reset busy held", {49'b0, busy}, 64'd0);
        m_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(4'd3, N); #1;
        chk("after reset reg3", valA, 64'd0);

        // ---------------- randomized vs model ----------------
        for (int k = 0; k < 400; k++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            #2;
            chk_model($sformatf("rnd%0d", k));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
